cpu_step_sequencer: RTL and testbench
=====================================

Name: cpu_step_sequencer

Overview:
Multi-cycle control FSM that sequences one RV32I instruction at a time through fetch, decode, execute, memory and writeback. It consumes the decoder's classification flags (wren, is_load, is_store, is_halt) and drives the instruction-register latch, PC update, register-file write enable and the instruction- and data-memory request handshakes. It sits between the decoder/ALU datapath and the memory interfaces, and is the single source of stage enables in the core.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory request may wait for ack before fault; 0 disables the timeout.
TIMEOUT_W, 5, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
imem_req  out  1  instruction fetch request, held until imem_ack
imem_ack  in  1  fetch data valid this cycle
ir_we  out  1  latch instruction word into IR (1-cycle pulse)
dec_wren  in  1  decoder: register write required
dec_is_load  in  1  decoder: load instruction
dec_is_store  in  1  decoder: store instruction
dec_is_halt  in  1  decoder: halt instruction
dmem_req  out  1  data memory request, held until dmem_ack
dmem_we  out  1  store when 1, load when 0; valid while dmem_req
dmem_ack  in  1  data access complete this cycle
pc_we  out  1  commit next PC (1-cycle pulse)
rf_we  out  1  register-file write strobe (1-cycle pulse)
halted  out  1  sticky, core stopped by halt
fault  out  1  sticky, memory timeout
state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset: state=S_FETCH; all outputs 0; wait counter 0. Reset asserted mid-handshake drops imem_req/dmem_req immediately (asynchronous).
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT.
- S_FETCH: imem_req=1. On imem_ack=1: ir_we=1 in the same cycle, then go to S_DECODE.
- S_DECODE: one cycle while decoder outputs settle. If dec_is_halt: go to S_HALT. Otherwise go to S_EXEC.
- S_EXEC: one ALU cycle. Load or store: go to S_MEM. Otherwise: go to S_WB.
- S_MEM: dmem_req=1; dmem_we=dec_is_store. On dmem_ack: a store goes to S_WB with rf_we suppressed; a load goes to S_WB.
- S_WB: pc_we=1; rf_we=dec_wren & ~dec_is_store. Then go to S_FETCH.
- Latency with zero-wait memory: ALU op takes 4 cycles (FETCH, DECODE, EXEC, WB); load/store takes 5.
- S_HALT: terminal. halted=1, no requests, pc_we=0. Leaves only on rst.
- Timeout: the wait counter increments each cycle in S_FETCH or S_MEM without ack, and clears on ack or state exit. When the counter equals TIMEOUT_CYCLES-1 with no ack: go to S_FAULT, fault=1, requests dropped. S_FAULT is terminal until rst.
- An ack arriving in the same cycle the counter hits its limit counts as success; no fault.
- Acks outside S_FETCH/S_MEM are ignored.
- Stage pulses: pc_we, rf_we and ir_we are each high for at most one cycle per instruction.

Optional Feature:
PERF_COUNT_EN: when defined, adds a 32-bit output cycle_cnt and a 32-bit output instret_cnt. Both clear on rst. cycle_cnt increments every cycle while not in S_HALT/S_FAULT. instret_cnt increments on each pc_we. Both wrap at 2^32. When not defined, these ports and the counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header holds the state encodings (S_FETCH=0 … S_FAULT=6) alongside the existing ENABLE/DISABLE defines.
- One natural sub-module: mem_wait_timer (counter, clear, limit compare, expired flag), instantiated once and shared by the fetch and mem states.

Test Plan:
- ADDI with immediate ack → ir_we@cycle 0, pc_we and rf_we@cycle 3, next imem_req@cycle 4.
- LW with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, then rf_we=1 for one cycle.
- SW with dec_wren=1 → dmem_we=1 during S_MEM; rf_we stays 0; pc_we pulses once.
- Halt decoded → halted=1 from the cycle after S_DECODE; no further imem_req for 20 cycles; rst returns to S_FETCH.
- imem_ack withheld, TIMEOUT_CYCLES=16 → fault=1 after 16 request cycles, imem_req=0. A second run with ack in exactly the 16th cycle → no fault.
- rst asserted mid-S_MEM → dmem_req=0 immediately; with PERF_COUNT_EN, both counters read 0.

Source files
------------

// File: rtl/cpu_step_sequencer_pkg.sv
// Shared definitions for the multi-cycle step sequencer: FSM state encodings
// and the project-wide ENABLE/DISABLE defines.
`ifndef ENABLE
`define ENABLE  1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

package cpu_step_sequencer_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/cpu_step_sequencer_mem_wait_timer.sv
// Wait counter shared by the fetch and data-memory handshakes; flags expiry
// on the last allowed wait cycle. TIMEOUT_CYCLES = 0 never expires.
module cpu_step_sequencer_mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] LIMIT =
        TIMEOUT_EN ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign expired = TIMEOUT_EN && (count == LIMIT);

endmodule

// File: rtl/cpu_step_sequencer.sv
// One-instruction-at-a-time control FSM for the RV32I core.
// Optional PERF_COUNT_EN adds cycle_cnt / instret_cnt performance counters.
//
//   state    | meaning
//   S_FETCH  | imem_req held; ack latches IR
//   S_DECODE | decoder settles; halt detected here
//   S_EXEC   | ALU cycle; loads/stores branch to S_MEM
//   S_MEM    | dmem_req held; dmem_we = store
//   S_WB     | pc_we pulse, rf_we unless store
//   S_HALT   | terminal, halted until rst
//   S_FAULT  | terminal, memory timeout until rst
module cpu_step_sequencer
    import cpu_step_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_we,
    input  logic       dec_wren,
    input  logic       dec_is_load,
    input  logic       dec_is_store,
    input  logic       dec_is_halt,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       pc_we,
    output logic       rf_we,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
`ifdef PERF_COUNT_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);

    state_t state_q, state_d;
    logic   timer_inc, timer_expired;

    cpu_step_sequencer_mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_mem_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .inc    (timer_inc),
        .clr    (~timer_inc | timer_expired),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_inc = 1'b0;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    timer_inc = 1'b1;
                    if (timer_expired) state_d = S_FAULT;
                end
            end
            S_DECODE: state_d = dec_is_halt ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (dec_is_load | dec_is_store) ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_is_store;
                if (dmem_ack) begin
                    state_d = S_WB;
                end else begin
                    timer_inc = 1'b1;
                    if (timer_expired) state_d = S_FAULT;
                end
            end
            S_WB: begin
                pc_we   = 1'b1;
                rf_we   = dec_wren & ~dec_is_store;
                state_d = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_d = S_FETCH;
        endcase
        // Reset is asynchronous: kill any in-flight handshake right away.
        if (rst) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            pc_we    = 1'b0;
            rf_we    = 1'b0;
            halted   = 1'b0;
            fault    = 1'b0;
        end
    end

    assign state = state_q;

`ifdef PERF_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_q != S_HALT && state_q != S_FAULT) cycle_cnt <= cycle_cnt + 1'b1;
            if (pc_we) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed self-checking bench for cpu_step_sequencer (default timeout of 16).
module tb_cpu_step_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_req, imem_ack = 1'b0, ir_we;
    logic       dec_wren = 1'b0, dec_is_load = 1'b0, dec_is_store = 1'b0, dec_is_halt = 1'b0;
    logic       dmem_req, dmem_we, dmem_ack = 1'b0;
    logic       pc_we, rf_we, halted, fault;
    logic [2:0] state;
`ifdef PERF_COUNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cpu_step_sequencer #(.TIMEOUT_CYCLES(16), .TIMEOUT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .ir_we       (ir_we),
        .dec_wren    (dec_wren),
        .dec_is_load (dec_is_load),
        .dec_is_store(dec_is_store),
        .dec_is_halt (dec_is_halt),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .pc_we       (pc_we),
        .rf_we       (rf_we),
        .halted      (halted),
        .fault       (fault),
        .state       (state)
`ifdef PERF_COUNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs may be changed afterwards, away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state, with an ack present that must be ignored.
        imem_ack = 1'b1;
        tick();
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_ir_we", 32'(ir_we), 0);
        chk("rst_pc_we", 32'(pc_we), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_fault", 32'(fault), 0);
        tick();
        rst = 1'b0;

        // ADDI, immediate ack: ir_we@0, pc_we/rf_we@3, imem_req@4.
        dec_wren = 1'b1;
        imem_ack = 1'b1;
        #1;
        chk("addi_c0_imem_req", 32'(imem_req), 1);
        chk("addi_c0_ir_we", 32'(ir_we), 1);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("addi_c1_state", 32'(state), 1);
        chk("addi_c1_ir_we", 32'(ir_we), 0);
        chk("addi_c1_imem_req", 32'(imem_req), 0);
        tick();
        #1;
        chk("addi_c2_state", 32'(state), 2);
        chk("addi_c2_pc_we", 32'(pc_we), 0);
        tick();
        #1;
        chk("addi_c3_state", 32'(state), 4);
        chk("addi_c3_pc_we", 32'(pc_we), 1);
        chk("addi_c3_rf_we", 32'(rf_we), 1);
        tick();
        #1;
        chk("addi_c4_imem_req", 32'(imem_req), 1);
        chk("addi_c4_pc_we", 32'(pc_we), 0);
        chk("addi_c4_rf_we", 32'(rf_we), 0);
`ifdef PERF_COUNT_EN
        chk("addi_cycle_cnt", cycle_cnt, 4);
        chk("addi_instret_cnt", instret_cnt, 1);
`endif

        // LW, dmem_ack after 3 wait cycles: dmem_req high 4 cycles.
        dec_is_load = 1'b1;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_wait_dmem_req", 32'(dmem_req), 1);
            chk("lw_wait_dmem_we", 32'(dmem_we), 0);
            chk("lw_wait_rf_we", 32'(rf_we), 0);
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        chk("lw_ack_dmem_req", 32'(dmem_req), 1);
        chk("lw_ack_state", 32'(state), 3);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("lw_wb_dmem_req", 32'(dmem_req), 0);
        chk("lw_wb_rf_we", 32'(rf_we), 1);
        chk("lw_wb_pc_we", 32'(pc_we), 1);
        tick();
        #1;
        chk("lw_next_rf_we", 32'(rf_we), 0);
        chk("lw_next_state", 32'(state), 0);

        // SW with dec_wren set: store, no register write.
        dec_is_load = 1'b0;
        dec_is_store = 1'b1;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("sw_mem_dmem_req", 32'(dmem_req), 1);
        chk("sw_mem_dmem_we", 32'(dmem_we), 1);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("sw_wb_rf_we", 32'(rf_we), 0);
        chk("sw_wb_pc_we", 32'(pc_we), 1);
        tick();
        #1;
        chk("sw_next_pc_we", 32'(pc_we), 0);
        chk("sw_next_state", 32'(state), 0);

        // Fetch ack arrives in exactly the 16th request cycle: no fault.
        dec_is_store = 1'b0;
        dec_wren = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        #1;
        chk("late_ack_state_c15", 32'(state), 0);
        chk("late_ack_imem_req_c15", 32'(imem_req), 1);
        imem_ack = 1'b1;
        #1;
        chk("late_ack_ir_we", 32'(ir_we), 1);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("late_ack_state", 32'(state), 1);
        chk("late_ack_fault", 32'(fault), 0);
        tick();
        tick();
        #1;
        chk("nowren_wb_rf_we", 32'(rf_we), 0);
        chk("nowren_wb_pc_we", 32'(pc_we), 1);
        tick();

        // Fetch ack withheld: fault after 16 request cycles.
        for (int i = 0; i < 16; i++) tick();
        #1;
        chk("timeout_state", 32'(state), 6);
        chk("timeout_fault", 32'(fault), 1);
        chk("timeout_imem_req", 32'(imem_req), 0);
        imem_ack = 1'b1;
        #1;
        chk("fault_ack_ignored", 32'(ir_we), 0);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("fault_sticky", 32'(fault), 1);
        rst = 1'b1;
        #1;
        chk("fault_rst_state", 32'(state), 0);
        chk("fault_rst_fault", 32'(fault), 0);
        tick();
        rst = 1'b0;

        // Halt decoded: terminal, no further fetches.
        dec_is_halt = 1'b1;
        imem_ack = 1'b1;
        tick();
        #1;
        chk("halt_decode_halted", 32'(halted), 0);
        tick();
        #1;
        chk("halt_state", 32'(state), 5);
        chk("halt_halted", 32'(halted), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            chk("halt_no_imem_req", 32'(imem_req), 0);
            chk("halt_no_pc_we", 32'(pc_we), 0);
        end
        imem_ack = 1'b0;
        dec_is_halt = 1'b0;
        rst = 1'b1;
        #1;
        chk("halt_rst_state", 32'(state), 0);
        chk("halt_rst_halted", 32'(halted), 0);
        tick();
        rst = 1'b0;

        // Reset asserted while a load is waiting in S_MEM.
        dec_is_load = 1'b1;
        dec_wren = 1'b1;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("midmem_dmem_req", 32'(dmem_req), 1);
        rst = 1'b1;
        #1;
        chk("midmem_rst_dmem_req", 32'(dmem_req), 0);
        chk("midmem_rst_state", 32'(state), 0);
`ifdef PERF_COUNT_EN
        chk("midmem_rst_cycle_cnt", cycle_cnt, 0);
        chk("midmem_rst_instret_cnt", instret_cnt, 0);
`endif
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_imem_req", 32'(imem_req), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
